// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin mux arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of v, scanning upward from start and wrapping modulo N_REQ.
  function automatic pick_t first_set(input logic [N_REQ-1:0] v,
                                      input logic [SEL_W-1:0] start);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = start + SEL_W'(i);
      if (!p.found && v[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_word.sv
// WIDTH-bit 4:1 word multiplexer driven by a 2-bit binary select.
module mux4_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (s)
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters sharing one word channel, with a
// per-tenure hold limit that only bites while another requester is waiting.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [WIDTH-1:0]   dout
);

  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n;
  logic [N_REQ-1:0] gnt_n, owner;
  logic [7:0]       hold_cnt, hold_n;
  logic [WIDTH-1:0] mux_out;
  pick_t            pick;
  logic             grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      gnt      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    gnt_n   = gnt;
    hold_n  = hold_cnt;
    pick    = '0;
    grant   = 1'b0;
    owner   = 4'b0001 << sel;
    case (state)
      IDLE: begin
        pick  = first_set(req, ptr);
        grant = pick.found;
      end
      BUSY: begin
        if (!req[sel]) begin
          // Release re-arbitrates from the owner's successor so a waiter
          // takes over on the very next edge without an idle bubble.
          pick  = first_set(req, sel + 2'd1);
          grant = pick.found;
          if (!pick.found) begin
            state_n = IDLE;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end else if (hold_cnt == HOLD_SAT) begin
          // Saturated: stay put unless someone else is waiting.
          pick  = first_set(req & ~owner, sel + 2'd1);
          grant = pick.found;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    if (grant) begin
      state_n = BUSY;
      sel_n   = pick.idx;
      gnt_n   = 4'b0001 << pick.idx;
      ptr_n   = pick.idx + 2'd1;
      hold_n  = '0;
    end
  end

  assign busy = (state == BUSY);

  mux4_word #(.WIDTH(WIDTH)) u_mux (
    .in0 (din[0*WIDTH +: WIDTH]),
    .in1 (din[1*WIDTH +: WIDTH]),
    .in2 (din[2*WIDTH +: WIDTH]),
    .in3 (din[3*WIDTH +: WIDTH]),
    .s   (sel),
    .out (mux_out)
  );

  assign dout = mux_out & {WIDTH{busy}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random
// request traffic checked against a tenure-counting reference model.
module tb_rr_mux_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [3:0]         req   = '0;
  logic [4*WIDTH-1:0] din   = '0;
  logic [3:0]         gnt;
  logic [1:0]         sel;
  logic               busy;
  logic [WIDTH-1:0]   dout;

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model: owner index (-1 when idle), next-priority pointer, last select,
  // and the number of cycles the current owner has held the channel.
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_sel    = 0;
  int m_tenure = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input logic [3:0] v, input int start);
    for (int i = 0; i < 4; i++)
      if (v[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] exp_dout();
    if (m_owner < 0) return '0;
    return din[m_sel*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_sel    = 0;
    m_tenure = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int g;
    g = -1;
    if (m_owner < 0) begin
      g = pick(r, m_ptr);
    end else if (!r[m_owner]) begin
      g = pick(r, m_owner + 1);
      if (g < 0) begin
        m_owner  = -1;
        m_tenure = 0;
      end
    end else if (m_tenure >= MAX_HOLD) begin
      g = pick(r & ~(4'b0001 << m_owner), m_owner + 1);
      if (g < 0) m_tenure++;
    end else begin
      m_tenure++;
    end
    if (g >= 0) begin
      m_owner  = g;
      m_sel    = g;
      m_ptr    = (g + 1) % 4;
      m_tenure = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".gnt"},  gnt,  (m_owner < 0) ? 32'd0 : 32'd1 << m_owner);
    chk({tag, ".sel"},  sel,  m_sel);
    chk({tag, ".busy"}, busy, (m_owner >= 0) ? 32'd1 : 32'd0);
    chk({tag, ".dout"}, dout, exp_dout());
  endtask

  task automatic step(input logic [3:0] r, input logic [31:0] d, input string tag);
    @(negedge clk);
    req = r;
    din = d;
    model_edge(r);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    req   = r;
    rst_n = 1'b0;
    #1;
    chk("rst.gnt",  gnt,  32'd0);
    chk("rst.sel",  sel,  32'd0);
    chk("rst.busy", busy, 32'd0);
    chk("rst.dout", dout, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;

    // Reset with everyone requesting, then full contention rotation.
    do_reset(4'b1111);
    step(4'b1111, $urandom, "rst_first");
    chk("rst_first_owner", gnt, 32'b0001);
    for (int k = 1; k <= 16; k++) begin
      step(4'b1111, $urandom, "contend");
      chk("contend_order", gnt, 32'd1 << ((k / MAX_HOLD) % 4));
    end

    // Single requester with a known data word.
    do_reset(4'b0000);
    step(4'b0100, 32'h00A5_0000, "single");
    chk("single_gnt",  gnt,  32'b0100);
    chk("single_sel",  sel,  32'd2);
    chk("single_dout", dout, 32'hA5);
    step(4'b0100, 32'h00A5_0000, "single_hold");
    step(4'b0000, 32'h00A5_0000, "single_drop");
    chk("single_idle_gnt",  gnt,  32'd0);
    chk("single_idle_dout", dout, 32'd0);

    // Early release hands straight to the waiting requester.
    do_reset(4'b0000);
    step(4'b0010, $urandom, "early");
    step(4'b1010, $urandom, "early");
    step(4'b1000, $urandom, "early_handoff");
    chk("early_b2b", gnt, 32'b1000);
    step(4'b0101, $urandom, "early_wrap");
    chk("early_wrap_gnt", gnt, 32'b0001);

    // Sole requester never times out; a newcomer preempts right away.
    do_reset(4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(4'b0001, $urandom, "sole");
      chk("sole_gnt", gnt, 32'b0001);
    end
    step(4'b0101, $urandom, "sole_preempt");
    chk("sole_preempt_gnt", gnt, 32'b0100);

    // Reset in the middle of requester 3's tenure.
    do_reset(4'b0000);
    step(4'b1000, $urandom, "midrst");
    chk("midrst_owner3", gnt, 32'b1000);
    do_reset(4'b1001);
    step(4'b1001, $urandom, "midrst_after");
    chk("midrst_restart", gnt, 32'b0001);

    // Random traffic; din also changes between edges to exercise the mux path.
    do_reset(4'b0000);
    r = '0;
    for (int i = 0; i < 400; i++) begin
      r = r ^ 4'($urandom & $urandom);
      step(r, $urandom, "rnd");
      din = $urandom;
      #1;
      chk("rnd.dout_comb", dout, exp_dout());
      if (i % 97 == 50) do_reset(r);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Four-requester round-robin arbiter that shares a single WIDTH-bit output channel. It drives the 2-bit select of a 4:1 word multiplexer, and it bounds each requester's tenure with a hold timer. It sits between four producer blocks and one shared consumer, so each producer sees a simple req/gnt handshake.

## Interface
- WIDTH, 8, data width of each requester's word and of dout
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester is pending; legal range 1..255
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  request per requester; a requester holds it high for as long as it wants the channel
- din  input  4*WIDTH  packed requester data; requester i occupies din[i*WIDTH +: WIDTH]
- gnt  output  4  one-hot grant, registered; all-zero when idle
- sel  output  2  mux select, registered; binary index of the granted requester
- busy  output  1  registered; high whenever gnt is non-zero
- dout  output  WIDTH  din word of the granted requester; all zeros when gnt is zero

## Operation
- State machine: IDLE and BUSY.
- IDLE: gnt=0, sel holds its last value, busy=0.
  - If any req bit is high, register a grant to the first requester found scanning up from ptr, modulo 4, and go to BUSY.
  - ptr is the priority pointer; reset value 0.
- BUSY, with owner c = sel:
  - hold_cnt counts cycles of the current tenure. It is 0 in the first grant cycle and saturates at MAX_HOLD-1.
  - req[c]=0 (release): the next state is chosen as if from IDLE with ptr=c+1. A pending requester is granted in the very next cycle with no idle bubble. If no requester is pending, go to IDLE.
  - req[c]=1, hold_cnt=MAX_HOLD-1, and another req bit high (timeout): grant the first other requester scanning from c+1. hold_cnt resets to 0.
  - req[c]=1, hold_cnt=MAX_HOLD-1, no other requester: c keeps the grant. hold_cnt stays saturated, so a new competitor preempts c after one cycle.
  - Otherwise c keeps the grant and hold_cnt increments.
- Every time a grant is issued to requester g, ptr becomes g+1 mod 4.
- gnt always equals the one-hot decode of sel while busy=1. gnt never has more than one bit set.
- dout = busy ? din[sel] : 0. This is combinational from registered sel/busy and live din.
- Async reset, including mid-tenure: gnt=0, sel=0, busy=0, ptr=0, hold_cnt=0, state IDLE. dout=0 immediately.
- Requests that arrive while another requester is granted wait; they are never lost as long as req stays high.
- Requests that rise and fall with no grant issued while they were high are ignored. There is no request latching.

## Timing
- Latency from req rising (sampled at edge N) to gnt at edge N+1 is 1 cycle.
- Owner dropping req at edge N: gnt changes at edge N+1, either to 0 or to the next owner.
- Tenure under contention is exactly MAX_HOLD cycles when the owner keeps req high.
- When all four request continuously, the steady-state grant order is 0,1,2,3,0,… with MAX_HOLD cycles each.
- There is no combinational path from req to any output. din-to-dout is combinational only.

## Structure
- Package rr_arb_pkg holds:
  - N_REQ=4 and SEL_W=2
  - the state encoding (IDLE=1'b0, BUSY=1'b1)
  - a function that returns the first set index in a 4-bit vector, scanning from a start index
- Sub-module mux4_word is a WIDTH-parameterised 4:1 word multiplexer (in0..in3, s[1:0], out). The arbiter instantiates it once for dout and ANDs its output with busy.
- Everything else lives in the top module: FSM, ptr, hold_cnt, and the grant/sel registers.

## Test plan
- Reset check: assert rst_n=0 mid-simulation with req=4'b1111. gnt=0, sel=0, busy=0 and dout=0 immediately. After release, the first grant goes to requester 0.
- Single request: req=4'b0100 and din[2]=8'hA5 at edge 0. At edge 1, gnt=4'b0100, sel=2, busy=1, dout=8'hA5. Drop req at edge 3; gnt=0 and dout=0 at edge 4.
- Full contention with MAX_HOLD=4 and req=4'b1111 held: gnt is 0001 for 4 cycles, then 0010 for 4, 0100 for 4, 1000 for 4, then back to 0001.
- Early release, back-to-back: owner 1 drops req after 2 cycles while req[3] is high. At the next edge gnt=1000 with no idle cycle, then ptr=0.
- Sole requester past timeout: only req[0] is high for 10 cycles, so gnt stays 0001 throughout. Raise req[2] at cycle 10; gnt=0100 one cycle later.
- Reset during tenure: requester 3 is granted, then rst_n=0 for 1 cycle with req unchanged. All outputs are zero, and after release requester 0 is granted, not 3.
